// File: rtl/row_decoder_5p_plus.sv
// Row decoder for the 5P+ encoded stream.
// Expands PIXEL / REPEAT / TIMESTAMP words into a valid/ready pixel stream,
// each pixel tagged with a running 45-bit timestamp.
module row_decoder_5p_plus #(
    parameter int PIX_W = 15,
    parameter int TS_W  = 45,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      encoded_data,
    input  logic             data_ready,
    output logic             enc_ready,
    output logic [PIX_W-1:0] pixel_out,
    output logic [TS_W-1:0]  tik_tok_out,
    output logic             pixel_valid,
    input  logic             out_ready,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PIX_W-1:0] r_pix;
    logic [PIX_W-1:0] w_pix_nxt;
    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  w_ts_nxt;
    logic [35:0]      r_shadow;
    logic [35:0]      w_shadow_nxt;
    logic [1:0]       r_exp_idx;
    logic [1:0]       w_exp_idx_nxt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_cnt_nxt;
    logic             r_have_pix;
    logic             w_have_pix_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_err;
    logic             w_err_nxt;

    // Word field decode
    logic             w_is_pix;
    logic             w_is_rep;
    logic [1:0]       w_seg_idx;
    logic [11:0]      w_seg_pay;
    logic [CNT_W-1:0] w_rep_n;
    logic             w_xfer;
    logic [TS_W-1:0]  w_ts_inc;

    assign w_is_pix  = ~encoded_data[15];
    assign w_is_rep  = (encoded_data[15:14] == 2'b10);
    assign w_seg_idx = encoded_data[13:12];
    assign w_seg_pay = encoded_data[11:0];
    assign w_rep_n   = encoded_data[CNT_W-1:0];
    assign w_xfer    = r_valid & out_ready;
    assign w_ts_inc  = r_ts + TS_W'(1);

    // Outputs come straight from registers
    assign enc_ready   = (r_state == ST_ACCEPT);
    assign pixel_out   = r_pix;
    assign tik_tok_out = r_ts;
    assign pixel_valid = r_valid;
    assign err         = r_err;

    // Next-state and next-datapath decode for the three-state controller
    always_comb begin
        w_state_nxt    = r_state;
        w_pix_nxt      = r_pix;
        w_ts_nxt       = r_ts;
        w_shadow_nxt   = r_shadow;
        w_exp_idx_nxt  = r_exp_idx;
        w_rep_cnt_nxt  = r_rep_cnt;
        w_have_pix_nxt = r_have_pix;
        w_valid_nxt    = r_valid;
        w_err_nxt      = r_err;

        case (r_state)
            ST_ACCEPT: begin
                if (data_ready) begin
                    if (w_is_pix) begin
                        w_pix_nxt      = encoded_data[PIX_W-1:0];
                        w_valid_nxt    = 1'b1;
                        w_have_pix_nxt = 1'b1;
                        w_state_nxt    = ST_HOLD;
                    end else if (w_is_rep) begin
                        if (w_rep_n == {CNT_W{1'b0}}) begin
                            // Zero-length repeat is legal and simply consumed
                            w_rep_cnt_nxt = r_rep_cnt;
                        end else if (r_have_pix) begin
                            w_rep_cnt_nxt = w_rep_n;
                            w_valid_nxt   = 1'b1;
                            w_state_nxt   = ST_REPEAT;
                        end else begin
                            // Nothing to repeat yet
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        if (w_seg_idx == r_exp_idx) begin
                            case (w_seg_idx)
                                2'd0: begin
                                    w_shadow_nxt[11:0] = w_seg_pay;
                                    w_exp_idx_nxt      = 2'd1;
                                end
                                2'd1: begin
                                    w_shadow_nxt[23:12] = w_seg_pay;
                                    w_exp_idx_nxt       = 2'd2;
                                end
                                2'd2: begin
                                    w_shadow_nxt[35:24] = w_seg_pay;
                                    w_exp_idx_nxt       = 2'd3;
                                end
                                2'd3: begin
                                    // Top segment carries only 9 meaningful bits
                                    w_ts_nxt      = {w_seg_pay[8:0], r_shadow};
                                    w_exp_idx_nxt = 2'd0;
                                end
                                default: begin
                                    w_exp_idx_nxt = 2'd0;
                                end
                            endcase
                        end else begin
                            w_err_nxt = 1'b1;
                            if (w_seg_idx == 2'd0) begin
                                // Out-of-order segment 0 restarts collection
                                w_shadow_nxt  = {24'd0, w_seg_pay};
                                w_exp_idx_nxt = 2'd1;
                            end else begin
                                w_shadow_nxt  = 36'd0;
                                w_exp_idx_nxt = 2'd0;
                            end
                        end
                    end
                end else begin
                    w_state_nxt = ST_ACCEPT;
                end
            end

            ST_HOLD: begin
                if (data_ready) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = r_err;
                end
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_ts_nxt    = w_ts_inc;
                    w_state_nxt = ST_ACCEPT;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end

            ST_REPEAT: begin
                if (data_ready) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt = r_err;
                end
                if (w_xfer) begin
                    w_ts_nxt = w_ts_inc;
                    if (r_rep_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        w_rep_cnt_nxt = {CNT_W{1'b0}};
                        w_valid_nxt   = 1'b0;
                        w_state_nxt   = ST_ACCEPT;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_state_nxt = ST_REPEAT;
                end
            end

            default: begin
                w_state_nxt = ST_ACCEPT;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any pending pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACCEPT;
            r_pix      <= {PIX_W{1'b0}};
            r_ts       <= {TS_W{1'b0}};
            r_shadow   <= 36'd0;
            r_exp_idx  <= 2'd0;
            r_rep_cnt  <= {CNT_W{1'b0}};
            r_have_pix <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pix      <= w_pix_nxt;
            r_ts       <= w_ts_nxt;
            r_shadow   <= w_shadow_nxt;
            r_exp_idx  <= w_exp_idx_nxt;
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_have_pix <= w_have_pix_nxt;
            r_valid    <= w_valid_nxt;
            r_err      <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_row_decoder_5p_plus.sv
// Self-checking bench for row_decoder_5p_plus: scoreboard of expected
// pixels plus a table of PIXEL vectors and hand-written corner sequences.
module tb_row_decoder_5p_plus;

    logic        clk;
    logic        rst_n;
    logic [15:0] encoded_data;
    logic        data_ready;
    logic        enc_ready;
    logic [14:0] pixel_out;
    logic [44:0] tik_tok_out;
    logic        pixel_valid;
    logic        out_ready;
    logic        err;

    row_decoder_5p_plus dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .encoded_data (encoded_data),
        .data_ready   (data_ready),
        .enc_ready    (enc_ready),
        .pixel_out    (pixel_out),
        .tik_tok_out  (tik_tok_out),
        .pixel_valid  (pixel_valid),
        .out_ready    (out_ready),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] pix;
        logic [44:0] ts;
    } exp_t;

    typedef struct {
        logic [15:0] word;
        logic [14:0] exp_pix;
    } vec_t;

    exp_t        sb_q[$];
    logic [44:0] model_ts;
    int          n_chk;
    int          n_pass;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Compare whatever transfers at the coming edge against the scoreboard
    task automatic mon();
        exp_t e;
        if (pixel_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pixel: got pix %0h ts %0h expected none", pixel_out, tik_tok_out);
            end else begin
                e = sb_q.pop_front();
                chk("pixel_out", {49'd0, pixel_out}, {49'd0, e.pix});
                chk("tik_tok_out", {19'd0, tik_tok_out}, {19'd0, e.ts});
            end
        end
    endtask

    task automatic step();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        while (!enc_ready && n < 300) begin
            step();
            n++;
        end
        if (!enc_ready) begin
            n_chk++;
            $display("FAIL enc_ready_timeout: got 0 expected 1");
        end
        encoded_data = w;
        data_ready   = 1'b1;
        step();
        data_ready   = 1'b0;
    endtask

    task automatic send_pix(input logic [14:0] p);
        exp_t e;
        e.pix = p;
        e.ts  = model_ts;
        sb_q.push_back(e);
        model_ts = model_ts + 45'd1;
        send({1'b0, p});
    endtask

    task automatic send_rep(input logic [14:0] p, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pix = p;
            e.ts  = model_ts;
            sb_q.push_back(e);
            model_ts = model_ts + 45'd1;
        end
        send({2'b10, 14'(n)});
    endtask

    task automatic load_ts(input logic [44:0] v);
        send({2'b11, 2'd0, v[11:0]});
        send({2'b11, 2'd1, v[23:12]});
        send({2'b11, 2'd2, v[35:24]});
        send({2'b11, 2'd3, 3'b000, v[44:36]});
        model_ts = v;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        data_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        model_ts = 45'd0;
    endtask

    task automatic drain();
        repeat (4) step();
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        model_ts     = 45'd0;
        encoded_data = 16'd0;
        data_ready   = 1'b0;
        out_ready    = 1'b1;
        rst_n        = 1'b0;

        tbl[0] = '{16'h0000, 15'h0000};
        tbl[1] = '{16'h7FFF, 15'h7FFF};
        tbl[2] = '{16'h2AAA, 15'h2AAA};
        tbl[3] = '{16'h5555, 15'h5555};
        tbl[4] = '{16'h0001, 15'h0001};
        tbl[5] = '{16'h4000, 15'h4000};

        // Reset values
        #3;
        chk("rst_enc_ready", {63'd0, enc_ready}, 64'd1);
        chk("rst_pixel_valid", {63'd0, pixel_valid}, 64'd0);
        chk("rst_pixel_out", {49'd0, pixel_out}, 64'd0);
        chk("rst_tik_tok", {19'd0, tik_tok_out}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        do_reset();

        // REPEAT with no prior pixel: dropped, error
        send(16'h8005);
        chk("rep_nopix_valid", {63'd0, pixel_valid}, 64'd0);
        chk("rep_nopix_err", {63'd0, err}, 64'd1);
        drain();

        // Segments 0,2: error, then an out-of-order segment 0 restarts collection
        do_reset();
        send(16'hC111);
        send(16'hE222);
        chk("seg_ooo_err", {63'd0, err}, 64'd1);
        send(16'hC333);
        send(16'hD444);
        send(16'hC9AB);
        send(16'hD678);
        send(16'hE345);
        send(16'hF012);
        model_ts = 45'h1_2345_6789_AB;
        send_pix(15'h1111);
        drain();

        // Timestamp load then a single pixel
        do_reset();
        load_ts(45'h1_2345_6789_AB);
        chk("ts_load_no_err", {63'd0, err}, 64'd0);
        send_pix(15'h24BB);
        chk("single_valid", {63'd0, pixel_valid}, 64'd1);
        step();
        chk("single_valid_drop", {63'd0, pixel_valid}, 64'd0);

        // Table of PIXEL words back to back
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.pix = tbl[i].exp_pix;
            e.ts  = model_ts;
            sb_q.push_back(e);
            model_ts = model_ts + 45'd1;
            send(tbl[i].word);
        end
        drain();

        // Zero-length REPEAT is consumed silently
        send(16'h8000);
        chk("rep0_err", {63'd0, err}, 64'd0);
        chk("rep0_enc_ready", {63'd0, enc_ready}, 64'd1);
        chk("rep0_valid", {63'd0, pixel_valid}, 64'd0);

        // PIXEL then REPEAT 68: 68 back-to-back repeats
        send_pix(15'h24BB);
        send_rep(15'h24BB, 68);
        for (int i = 0; i < 68; i++) begin
            chk("rep_valid", {63'd0, pixel_valid}, 64'd1);
            chk("rep_enc_ready", {63'd0, enc_ready}, 64'd0);
            step();
        end
        chk("rep_end_valid", {63'd0, pixel_valid}, 64'd0);
        chk("rep_end_enc_ready", {63'd0, enc_ready}, 64'd1);
        drain();

        // Backpressure in HOLD with a stray strobe
        out_ready = 1'b0;
        send_pix(15'h0ABC);
        for (int i = 0; i < 5; i++) begin
            chk("hold_pix", {49'd0, pixel_out}, {49'd0, 15'h0ABC});
            chk("hold_ts", {19'd0, tik_tok_out}, {19'd0, model_ts - 45'd1});
            chk("hold_enc_ready", {63'd0, enc_ready}, 64'd0);
            if (i == 2) begin
                chk("hold_err_before", {63'd0, err}, 64'd0);
                encoded_data = 16'h1234;
                data_ready   = 1'b1;
            end
            step();
            data_ready = 1'b0;
        end
        chk("hold_err_after", {63'd0, err}, 64'd1);
        out_ready = 1'b1;
        drain();

        // Timestamp wrap
        do_reset();
        load_ts(45'h1FFF_FFFF_FFFF);
        send_pix(15'h0101);
        send_pix(15'h0202);
        send_pix(15'h0303);
        chk("wrap_last_ts", {19'd0, model_ts}, {19'd0, 45'd2});
        drain();

        // Reset mid-REPEAT
        do_reset();
        send_pix(15'h0555);
        send_rep(15'h0555, 20);
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {63'd0, pixel_valid}, 64'd0);
        chk("async_enc_ready", {63'd0, enc_ready}, 64'd1);
        chk("async_pix", {49'd0, pixel_out}, 64'd0);
        chk("async_ts", {19'd0, tik_tok_out}, 64'd0);
        chk("async_err", {63'd0, err}, 64'd0);
        sb_q.delete();
        model_ts = 45'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("post_rst_valid", {63'd0, pixel_valid}, 64'd0);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/row_decoder_5p_plus.md
ROW_DECODER_5P_PLUS -- requirements
Module: row_decoder_5p_plus

Interface
REQ-001 SHALL have parameter PIX_W, 15, pixel word width (five 3-bit pixels).
REQ-002 SHALL have parameter TS_W, 45, timestamp (tik_tok) width.
REQ-003 SHALL have parameter CNT_W, 14, repeat-count field width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port encoded_data  input  16  encoded word from the 5P+ row encoder.
REQ-007 SHALL have port data_ready  input  1  encoded_data valid strobe, one cycle per word.
REQ-008 SHALL have port enc_ready  output  1  decoder can accept a word this cycle.
REQ-009 SHALL have port pixel_out  output  PIX_W  decoded pixel word.
REQ-010 SHALL have port tik_tok_out  output  TS_W  timestamp of pixel_out.
REQ-011 SHALL have port pixel_valid  output  1  pixel_out/tik_tok_out valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts pixel when pixel_valid=1.
REQ-013 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL decode words by tag: bit15=0 -> PIXEL (payload [14:0]); bits[15:14]=10 -> REPEAT (count N=[13:0]); bits[15:14]=11 -> TIMESTAMP segment (index [13:12], payload [11:0]).
REQ-015 SHALL accept a word only on a cycle with data_ready=1 and enc_ready=1.
REQ-016 SHALL implement states ACCEPT (enc_ready=1), HOLD (enc_ready=0), REPEAT (enc_ready=0).
REQ-017 In ACCEPT, accepted PIXEL SHALL register pixel_out=payload, set pixel_valid=1 at the same edge, set have_pix, go HOLD.
REQ-018 In HOLD, pixel_valid&out_ready SHALL clear pixel_valid, increment timestamp counter, return to ACCEPT; without out_ready, outputs hold unchanged.
REQ-019 In ACCEPT, accepted REPEAT with N>0 and have_pix=1 SHALL set rep_cnt=N, pixel_valid=1, pixel_out unchanged (last pixel), go REPEAT.
REQ-020 In REPEAT, each out_ready cycle SHALL emit one pixel, increment timestamp, decrement rep_cnt; transfer with rep_cnt=1 SHALL clear pixel_valid and go ACCEPT (exactly N pixels, back-to-back at one per cycle when out_ready held high).
REQ-021 REPEAT with N=0 SHALL be consumed with no output, no error.
REQ-022 REPEAT with have_pix=0 SHALL be dropped and set err.
REQ-023 TIMESTAMP segments SHALL arrive in order 0,1,2,3 mapping to timestamp bits [11:0],[23:12],[35:24],[44:36]; segment 3 payload bits [11:9] ignored.
REQ-024 Segments SHALL be collected in a shadow register; accepting segment 3 SHALL load the full shadow into the timestamp counter at that edge; expected index returns to 0.
REQ-025 Out-of-order segment index SHALL set err, discard the partial shadow, reset expected index to 0; an out-of-order segment 0 SHALL be taken as a fresh start.
REQ-026 tik_tok_out SHALL equal the timestamp counter while pixel_valid=1; counter SHALL increment by 1 per transferred pixel, wrapping 2^TS_W-1 -> 0.
REQ-027 data_ready=1 while enc_ready=0 SHALL drop the word and set err.
REQ-028 Sustained throughput SHALL be one PIXEL word per two cycles (matches 20 MHz data on 40 MHz clk) and one pixel per cycle during REPEAT.
REQ-029 err SHALL remain 1 until reset.

Reset
REQ-030 rst_n=0 SHALL immediately force state ACCEPT, enc_ready=1, pixel_valid=0, pixel_out=0, tik_tok_out=0, timestamp counter=0, shadow=0, expected index=0, rep_cnt=0, have_pix=0, err=0.
REQ-031 Reset asserted mid-HOLD or mid-REPEAT SHALL abandon the pending pixel(s); no pixel emitted after release until a new PIXEL word.

Verification
REQ-032 TIMESTAMP segs 0..3 encoding 45'h1_2345_6789_AB, then PIXEL 15'h24BB, out_ready=1 -> one pixel 15'h24BB with tik_tok_out=45'h1_2345_6789_AB, pixel_valid high one cycle.
REQ-033 PIXEL 15'h24BB then REPEAT N=68 with out_ready=1 -> 69 pixels 15'h24BB total, timestamps consecutive, last 68 back-to-back, enc_ready=0 throughout.
REQ-034 out_ready=0 for 5 cycles during HOLD -> pixel_out/tik_tok_out stable, enc_ready=0; strobe during that window -> word dropped, err=1.
REQ-035 Timestamp loaded 45'h1FFF_FFFF_FFFF then three PIXEL words -> tik_tok_out 45'h1FFF_FFFF_FFFF, 0, 1.
REQ-036 REPEAT N=5 right after reset -> no output, err=1; segments 0,2 -> err=1, shadow discarded.
REQ-037 rst_n low mid-REPEAT (rep_cnt=10) -> pixel_valid=0 asynchronously, all outputs at REQ-030 values, no further pixels after release.
